twiddle_mult_ctrl: RTL and testbench

- Streaming controller for the complex twiddle multiply between radix-2^2 butterfly stages of an N-point SDF FFT.
- Tracks sample position within the frame and computes the twiddle exponent.
- Addresses an external twiddle ROM, drives a pipelined complex multiply, then rounds the 2*WIDTH product back to WIDTH.
- Sits between BF2II of one stage and BF2I of the next; no backpressure (continuous-stream pipeline).

---
 rtl/twiddle_mult_ctrl.sv | 139 +++++++++++++
 tb/tb_twiddle_mult_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/twiddle_mult_ctrl.sv
// rtl/twiddle_mult_ctrl.sv - SDF FFT inter-stage twiddle multiply controller, 3-cycle latency.
// Define TW_SATURATE_EN to clamp rounded products; otherwise they wrap to WIDTH bits.
module twiddle_mult_ctrl #(
  parameter int LOG_N = 6,
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    di_en,
  input  logic signed [WIDTH-1:0] di_re,
  input  logic signed [WIDTH-1:0] di_im,
  output logic [LOG_N-1:0]        tw_addr,
  input  logic signed [WIDTH-1:0] tw_re,
  input  logic signed [WIDTH-1:0] tw_im,
  output logic                    do_en,
  output logic signed [WIDTH-1:0] do_re,
  output logic signed [WIDTH-1:0] do_im,
  output logic                    frame_last
);

  localparam int PW = 2 * WIDTH + 1;
  localparam logic signed [PW-1:0] RND = PW'(1) << (WIDTH - 2);

  logic [LOG_N-1:0]          cnt;
  logic [LOG_N-1:0]          k;
  logic [LOG_N-1:0]          m_ext;

  logic                      s1_vld, s1_byp, s1_last;
  logic signed [WIDTH-1:0]   s1_re, s1_im;
  logic                      s2_vld, s2_byp, s2_last;
  logic signed [WIDTH-1:0]   s2_re, s2_im;
  logic signed [2*WIDTH-1:0] pp_rr, pp_ii, pp_ri, pp_ir;

  logic signed [PW-1:0]      sum_re, sum_im, sh_re, sh_im;
  logic signed [WIDTH-1:0]   res_re, res_im;

  // Exponent multiplier per quarter of the span: 0, 2, 1, 3.
  always_comb begin
    m_ext = {2'b00, cnt[LOG_N-3:0]};
    case (cnt[LOG_N-1:LOG_N-2])
      2'd0:    k = '0;
      2'd1:    k = m_ext << 1;
      2'd2:    k = m_ext;
      default: k = m_ext + (m_ext << 1);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      tw_addr <= '0;
      s1_vld  <= 1'b0;
      s1_byp  <= 1'b0;
      s1_last <= 1'b0;
      s1_re   <= '0;
      s1_im   <= '0;
    end else begin
      s1_vld <= di_en;
      if (di_en) begin
        cnt     <= cnt + 1'b1;
        tw_addr <= k;
        s1_byp  <= (k == '0);
        s1_last <= &cnt;
        s1_re   <= di_re;
        s1_im   <= di_im;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld  <= 1'b0;
      s2_byp  <= 1'b0;
      s2_last <= 1'b0;
      s2_re   <= '0;
      s2_im   <= '0;
      pp_rr   <= '0;
      pp_ii   <= '0;
      pp_ri   <= '0;
      pp_ir   <= '0;
    end else begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_byp  <= s1_byp;
        s2_last <= s1_last;
        s2_re   <= s1_re;
        s2_im   <= s1_im;
        pp_rr   <= s1_re * tw_re;
        pp_ii   <= s1_im * tw_im;
        pp_ri   <= s1_re * tw_im;
        pp_ir   <= s1_im * tw_re;
      end
    end
  end

  // One guard bit keeps the (-max)*(-max) sums exact before rounding.
  always_comb begin
    sum_re = $signed({pp_rr[2*WIDTH-1], pp_rr}) - $signed({pp_ii[2*WIDTH-1], pp_ii});
    sum_im = $signed({pp_ri[2*WIDTH-1], pp_ri}) + $signed({pp_ir[2*WIDTH-1], pp_ir});
    sh_re  = (sum_re + RND) >>> (WIDTH - 1);
    sh_im  = (sum_im + RND) >>> (WIDTH - 1);
  end

`ifdef TW_SATURATE_EN
  localparam logic signed [PW-1:0] MAXV = {{(PW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] MINV = {{(PW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  always_comb begin
    if (sh_re > MAXV)      res_re = MAXV[WIDTH-1:0];
    else if (sh_re < MINV) res_re = MINV[WIDTH-1:0];
    else                   res_re = sh_re[WIDTH-1:0];
    if (sh_im > MAXV)      res_im = MAXV[WIDTH-1:0];
    else if (sh_im < MINV) res_im = MINV[WIDTH-1:0];
    else                   res_im = sh_im[WIDTH-1:0];
  end
`else
  logic unused_hi;
  assign unused_hi = ^{sh_re[PW-1:WIDTH], sh_im[PW-1:WIDTH]};
  assign res_re = sh_re[WIDTH-1:0];
  assign res_im = sh_im[WIDTH-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      do_en      <= 1'b0;
      frame_last <= 1'b0;
      do_re      <= '0;
      do_im      <= '0;
    end else begin
      do_en      <= s2_vld;
      frame_last <= s2_vld & s2_last;
      if (s2_vld) begin
        do_re <= s2_byp ? s2_re : res_re;
        do_im <= s2_byp ? s2_im : res_im;
      end
    end
  end

endmodule

// File: tb/tb_twiddle_mult_ctrl.sv
// tb/tb_twiddle_mult_ctrl.sv - scoreboard bench for twiddle_mult_ctrl with a behavioural FFT twiddle model.
module tb_twiddle_mult_ctrl;

  localparam int LOG_N = 4;
  localparam int N     = 1 << LOG_N;
  localparam int W     = 16;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                di_en;
  logic signed [W-1:0] di_re, di_im;
  logic [LOG_N-1:0]    tw_addr;
  logic signed [W-1:0] tw_re, tw_im;
  logic                do_en;
  logic signed [W-1:0] do_re, do_im;
  logic                frame_last;

  logic signed [W-1:0] rom_re [N];
  logic signed [W-1:0] rom_im [N];

  assign tw_re = rom_re[tw_addr];
  assign tw_im = rom_im[tw_addr];

  twiddle_mult_ctrl #(.LOG_N(LOG_N), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .di_en(di_en), .di_re(di_re), .di_im(di_im),
    .tw_addr(tw_addr), .tw_re(tw_re), .tw_im(tw_im),
    .do_en(do_en), .do_re(do_re), .do_im(do_im), .frame_last(frame_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int due; logic signed [W-1:0] re; logic signed [W-1:0] im; logic last; } out_t;
  typedef struct { int due; logic [LOG_N-1:0] k; } addr_t;
  out_t  oq[$];
  addr_t aq[$];

  int nchk = 0;
  int nerr = 0;
  int mcnt = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Exponent from the frame position: quarter q scales the in-quarter index m by 0,2,1,3.
  function automatic int calc_k(input int c);
    int q, m;
    q = c / (N / 4);
    m = c % (N / 4);
    case (q)
      0: return 0;
      1: return 2 * m;
      2: return m;
      default: return 3 * m;
    endcase
  endfunction

  function automatic logic signed [W-1:0] fix(input longint p);
    longint s;
    s = (p + (longint'(1) << (W - 2))) >>> (W - 1);
`ifdef TW_SATURATE_EN
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
`endif
    return s[W-1:0];
  endfunction

  function automatic logic signed [W-1:0] rnd16();
    int r;
    r = $urandom_range(0, 7);
    if (r == 0) return 16'sh8000;
    if (r == 1) return 16'sh7fff;
    return W'($urandom);
  endfunction

  task automatic issue(input bit en, input logic signed [W-1:0] re, input logic signed [W-1:0] im);
    int k;
    longint ar, ai, br, bi;
    out_t o;
    @(negedge clk);
    di_en = en;
    di_re = re;
    di_im = im;
    if (en) begin
      k = calc_k(mcnt);
      aq.push_back('{due: cyc + 1, k: LOG_N'(k)});
      o.due  = cyc + 3;
      o.last = (mcnt == N - 1);
      if (k == 0) begin
        o.re = re;
        o.im = im;
      end else begin
        ar = re; ai = im; br = rom_re[k]; bi = rom_im[k];
        o.re = fix(ar * br - ai * bi);
        o.im = fix(ar * bi + ai * br);
      end
      oq.push_back(o);
      mcnt = (mcnt + 1) % N;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) issue(1'b0, '0, '0);
  endtask

  task automatic advance_to(input int p);
    while (mcnt != p) issue(1'b1, rnd16(), rnd16());
  endtask

  task automatic set_rom(input logic signed [W-1:0] re, input logic signed [W-1:0] im);
    idle(5);
    for (int i = 0; i < N; i++) begin
      rom_re[i] = re;
      rom_im[i] = im;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (aq.size() > 0 && aq[0].due == cyc) begin
        addr_t a;
        a = aq.pop_front();
        chk("tw_addr", tw_addr, a.k);
      end
      while (oq.size() > 0 && oq[0].due < cyc) begin
        void'(oq.pop_front());
        chk("stale_output", 0, 1);
      end
      if (do_en) begin
        if (oq.size() == 0 || oq[0].due != cyc) begin
          chk("unexpected_do_en", do_en, 0);
        end else begin
          out_t o;
          o = oq.pop_front();
          chk("do_re", do_re, o.re);
          chk("do_im", do_im, o.im);
          chk("frame_last", frame_last, o.last);
        end
      end else begin
        chk("frame_last_idle", frame_last, 0);
        if (oq.size() > 0 && oq[0].due == cyc) begin
          void'(oq.pop_front());
          chk("missing_do_en", do_en, 1);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    di_en = 1'b0;
    di_re = '0;
    di_im = '0;
    for (int i = 0; i < N; i++) begin
      rom_re[i] = rnd16();
      rom_im[i] = rnd16();
    end
    repeat (3) @(negedge clk);
    chk("rst_do_en", do_en, 0);
    chk("rst_frame_last", frame_last, 0);
    chk("rst_do_re", do_re, 0);
    chk("rst_do_im", do_im, 0);
    chk("rst_tw_addr", tw_addr, 0);
    rst_n = 1'b1;

    // Two back-to-back frames: address order and frame_last placement.
    for (int i = 0; i < 2 * N; i++) issue(1'b1, rnd16(), rnd16());

    advance_to(0);
    issue(1'b1, -16'sd32768, 16'sd12345);

    set_rom(16'sd0, -16'sd32768);
    advance_to(5);
    issue(1'b1, 16'sd16384, 16'sd0);

    set_rom(16'sd16384, 16'sd0);
    advance_to(5);
    issue(1'b1, 16'sd3, 16'sd0);

    set_rom(-16'sd32768, -16'sd32768);
    advance_to(5);
    issue(1'b1, -16'sd32768, -16'sd32768);
    advance_to(13);
    issue(1'b1, -16'sd32768, -16'sd32768);

    issue(1'b1, rnd16(), rnd16());
    idle(2);
    issue(1'b1, rnd16(), rnd16());
    issue(1'b1, rnd16(), rnd16());

    // Asynchronous reset in the middle of a stream.
    for (int i = 0; i < 7; i++) issue(1'b1, 16'sd1000 + 16'(i), 16'sd77);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_do_en", do_en, 0);
    chk("async_frame_last", frame_last, 0);
    chk("async_do_re", do_re, 0);
    chk("async_do_im", do_im, 0);
    chk("async_tw_addr", tw_addr, 0);
    aq.delete();
    oq.delete();
    mcnt  = 0;
    di_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    idle(5);
    for (int i = 0; i < N; i++) begin
      rom_re[i] = rnd16();
      rom_im[i] = rnd16();
    end
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) < 7) issue(1'b1, rnd16(), rnd16());
      else issue(1'b0, rnd16(), rnd16());
    end

    idle(6);
    chk("drain_out_queue", oq.size(), 0);
    chk("drain_addr_queue", aq.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
